// File: rtl/consmax_ctrl_if.sv
// Config stream, upstream score valids and LUT/shift outputs of the ConSmax sequencer.
interface consmax_ctrl_if #(
  parameter int LUT_ADDR  = 4,
  parameter int LUT_DATA  = 16,
  parameter int CDATA_BIT = 8,
  parameter int NUM_HEAD  = 8
);
  logic                  cfg_in_valid;
  logic                  cfg_in_ready;
  logic                  cfg_in_cmd;
  logic [LUT_ADDR:0]     cfg_in_addr;
  logic [LUT_DATA-1:0]   cfg_in_data;
  logic [NUM_HEAD-1:0]   up_valid;
  logic                  up_ready;
  logic [NUM_HEAD-1:0]   idata_valid_o;
  logic                  lut_wen;
  logic [LUT_ADDR:0]     lut_waddr;
  logic [LUT_DATA-1:0]   lut_wdata;
  logic [CDATA_BIT-1:0]  cfg_consmax_shift;
  logic                  busy;
  logic                  lut_loaded;

  modport master (
    output cfg_in_valid, cfg_in_cmd, cfg_in_addr, cfg_in_data, up_valid,
    input  cfg_in_ready, up_ready, idata_valid_o, lut_wen, lut_waddr, lut_wdata,
           cfg_consmax_shift, busy, lut_loaded
  );

  modport slave (
    input  cfg_in_valid, cfg_in_cmd, cfg_in_addr, cfg_in_data, up_valid,
    output cfg_in_ready, up_ready, idata_valid_o, lut_wen, lut_waddr, lut_wdata,
           cfg_consmax_shift, busy, lut_loaded
  );
endinterface

// File: rtl/consmax_ctrl.sv
// Stalls score traffic and drains the ConSmax pipeline before applying LUT / shift
// config beats; passes per-head valids straight through otherwise.
module consmax_ctrl #(
  parameter int LUT_ADDR  = 4,
  parameter int LUT_DATA  = 16,
  parameter int CDATA_BIT = 8,
  parameter int NUM_HEAD  = 8,
  parameter int PIPE_LAT  = 3
) (
  input  logic          clk,
  input  logic          rstn,
  consmax_ctrl_if.slave ctrl_if
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int LCW = LUT_ADDR + 2;
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(PIPE_LAT - 1);
  localparam logic [LCW-1:0] LOAD_FULL  = LCW'(2 * (1 << LUT_ADDR));

  logic [1:0]           state_q, state_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
  logic                 lut_wen_q;
  logic [LUT_ADDR:0]    lut_waddr_q;
  logic [LUT_DATA-1:0]  lut_wdata_q;
  logic [CDATA_BIT-1:0] shift_q;
  logic [LCW-1:0]       load_cnt_q;

  logic in_idle;
  logic up_ready_w;
  logic accept;

  assign in_idle    = (state_q == ST_IDLE);
  // Config wins over data in the same IDLE cycle, so upstream is held off immediately.
  assign up_ready_w = in_idle & ~ctrl_if.cfg_in_valid;
  assign accept     = ctrl_if.cfg_in_valid & (state_q == ST_WRITE);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_if.cfg_in_valid) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_WRITE;
        else                   drain_cnt_d = drain_cnt_q - DCW'(1);
      end
      ST_WRITE: begin
        if (!ctrl_if.cfg_in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      lut_wen_q   <= 1'b0;
      lut_waddr_q <= '0;
      lut_wdata_q <= '0;
      shift_q     <= '0;
      load_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      lut_wen_q   <= accept & ~ctrl_if.cfg_in_cmd;
      if (accept && !ctrl_if.cfg_in_cmd) begin
        lut_waddr_q <= ctrl_if.cfg_in_addr;
        lut_wdata_q <= ctrl_if.cfg_in_data;
      end
      if (accept && ctrl_if.cfg_in_cmd) shift_q <= ctrl_if.cfg_in_data[CDATA_BIT-1:0];
      // Counts writes, not unique addresses; saturates once both LUTs' worth has landed.
      if (lut_wen_q && (load_cnt_q != LOAD_FULL)) load_cnt_q <= load_cnt_q + LCW'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_HEAD; gi++) begin : g_head
    assign ctrl_if.idata_valid_o[gi] = ctrl_if.up_valid[gi] & up_ready_w;
  end

  assign ctrl_if.up_ready          = up_ready_w;
  assign ctrl_if.cfg_in_ready      = (state_q == ST_WRITE);
  assign ctrl_if.busy              = ~in_idle;
  assign ctrl_if.lut_wen           = lut_wen_q;
  assign ctrl_if.lut_waddr         = lut_waddr_q;
  assign ctrl_if.lut_wdata         = lut_wdata_q;
  assign ctrl_if.cfg_consmax_shift = shift_q;
  assign ctrl_if.lut_loaded        = (load_cnt_q == LOAD_FULL);

endmodule
